tamagotchi_btn_cond: RTL
========================

# tamagotchi_btn_cond

- Conditions the raw push-buttons of the tamagotchi board (salud, energia, hambre, diversion, reset, test) before they reach `tamagotchi_fsm`.
- Per button: synchronises, debounces, emits a one-cycle press event and, optionally, a one-cycle long-press event.
- `tamagotchi_fsm` sees only clean, single-cycle `btn_*` pulses. Long-press on `btn_test` enters test mode.

## Interface
Parameters:
- `N_BTN`, 6, number of buttons; index map 0 salud, 1 energia, 2 hambre, 3 diversion, 4 reset, 5 test
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept an edge (20 ms at 50 MHz)
- `LONG_CYCLES`, 250_000_000, hold time after the press event before the long event fires (5 s)
- `ACTIVE_LOW_IN`, 1, 1 = raw input pressed when 0

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `btn_raw`  in  N_BTN  raw pad inputs, asynchronous to `clk`
- `btn_level`  out  N_BTN  debounced level, 1 = pressed
- `btn_press`  out  N_BTN  one-cycle pulse per accepted press
- `btn_long`  out  N_BTN  one-cycle pulse per long hold

## Operation
- Input stage:
  - Two-flop synchroniser per bit.
  - Input is inverted when `ACTIVE_LOW_IN` = 1, so internal `s` = 1 means pressed.
- Each button has an independent FSM, a debounce counter `deb_cnt` and a hold counter `hold_cnt`.
  - Counter widths are `$clog2(param+1)`.
  - Both counters saturate and never wrap.
- FSM states:
  - IDLE: `deb_cnt`=0, `hold_cnt`=0.
    - `s`=1 → DEB_PRESS.
  - DEB_PRESS: `deb_cnt`++ each cycle `s`=1.
    - `s`=0 → IDLE (glitch rejected, no event).
    - `deb_cnt` reaches DEBOUNCE_CYCLES → PRESSED; `btn_press`=1 for that one cycle.
  - PRESSED: `hold_cnt`++ each cycle.
    - `hold_cnt` reaches LONG_CYCLES → `btn_long`=1 for one cycle → HELD.
    - `s`=0 → DEB_RELEASE, with `deb_cnt` cleared.
  - HELD: `hold_cnt` frozen.
    - `s`=0 → DEB_RELEASE.
  - DEB_RELEASE: `deb_cnt`++ each cycle `s`=0.
    - `s`=1 → back to the state it came from (PRESSED or HELD); no new `btn_press`.
    - `deb_cnt` reaches DEBOUNCE_CYCLES → IDLE.
    - `hold_cnt` keeps counting when entered from PRESSED; `btn_long` may fire here, once.
- `btn_level`=1 in PRESSED, HELD and DEB_RELEASE; 0 otherwise.
- Boundary rules:
  - `btn_long` fires at most once per accepted press.
  - `btn_press` never re-fires without passing through IDLE.
  - Simultaneous presses on different buttons are independent; several `btn_press` bits may assert in the same cycle.
  - Outputs are never combinationally dependent on `btn_raw`.

## Timing
- Reset (asynchronous assert, synchronous release by `clk`):
  - All FSMs go to IDLE, counters to 0.
  - Synchroniser flops go to the inactive level (1 if ACTIVE_LOW_IN, else 0).
  - `btn_level`, `btn_press`, `btn_long` = 0.
- Reset mid-debounce or mid-hold aborts with no event. After release, a still-held button goes through the full debounce again and produces a fresh `btn_press`.
- Press latency:
  - Edge 0 is the first `clk` edge sampling a stable pressed raw input.
  - `btn_press` is high in the cycle after edge 2+DEBOUNCE_CYCLES.
  - `btn_level` rises with it.
- Long latency: `btn_long` asserts exactly LONG_CYCLES cycles after the `btn_press` cycle.
- Release latency: `btn_level` falls 2+DEBOUNCE_CYCLES edges after raw release.
- All outputs are registered.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - `hold_cnt`, the HELD state and `btn_long` logic are compiled in, as above.
- `BTN_LONG_PRESS_EN` undefined:
  - No `hold_cnt`, no HELD state.
  - PRESSED exits only to DEB_RELEASE.
  - `btn_long` is tied to 0; port list is unchanged.

## Test plan
All scenarios use N_BTN=6, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW_IN=1, macro defined unless noted.
- Clean press: `btn_raw[0]` driven 0 and held.
  - `btn_press[0]`=1 for exactly one cycle after edge 6.
  - `btn_level[0]`=1 from then on.
  - Other bits stay 0.
- Bounce rejection: `btn_raw[1]` toggles 0/1 every 2 cycles for 40 cycles, then returns to 1 → no `btn_press`, `btn_level[1]` stays 0.
- Long press: `btn_raw[5]` held 0 for 30 cycles.
  - One `btn_press[5]` pulse, then one `btn_long[5]` pulse 16 cycles later, nothing more.
  - Build with the macro undefined: `btn_long` stays 0.
- Release glitch: after a press, raw goes to 1 for 2 cycles, then back to 0.
  - `btn_level` stays 1, no second `btn_press`.
  - A final release held 10 cycles drops `btn_level` after 6 edges.
- Simultaneous: `btn_raw[2]` and `btn_raw[3]` pressed on the same edge → `btn_press[2]` and `btn_press[3]` assert in the same cycle.
- Reset mid-hold: assert `reset`=0 at cycle 10 of a hold, release at cycle 12.
  - Outputs go to 0 immediately.
  - With the button still held, a new `btn_press` arrives 6 edges after reset release.

Source files
------------

// File: rtl/tamagotchi_btn_cond.sv
// tamagotchi_btn_cond: synchronise, debounce and pulse-detect the board push-buttons.
// Long-press detection is compiled in only when BTN_LONG_PRESS_EN is defined.
module tamagotchi_btn_cond #(
    parameter int unsigned N_BTN           = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 250_000_000,
    parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_long
);
    localparam int unsigned   DW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FULL = DW'(DEBOUNCE_CYCLES);
`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned   HW        = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(LONG_CYCLES);
`endif

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        DEB_RELEASE = 3'd3
`ifdef BTN_LONG_PRESS_EN
        , HELD      = 3'd4
`endif
    } state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] s;

    // Two-flop synchroniser; reset parks it at the released pad level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= {N_BTN{ACTIVE_LOW_IN}};
            sync2 <= {N_BTN{ACTIVE_LOW_IN}};
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign s = ACTIVE_LOW_IN ? ~sync2 : sync2;

`ifndef BTN_LONG_PRESS_EN
    logic unused_long;
    assign unused_long = (LONG_CYCLES == 0);
    assign btn_long    = '0;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t        state;
        logic [DW-1:0] deb_cnt;
        logic          level_q;
        logic          press_q;
`ifdef BTN_LONG_PRESS_EN
        logic [HW-1:0] hold_cnt;
        logic          ret_held;
        logic          long_q;
        logic          long_hit;

        // ret_held doubles as the "long already fired" flag for this press
        assign long_hit    = !ret_held && (hold_cnt == HOLD_LAST);
        assign btn_long[i] = long_q;
`endif
        assign btn_level[i] = level_q;
        assign btn_press[i] = press_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                deb_cnt <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                hold_cnt <= '0;
                ret_held <= 1'b0;
                long_q   <= 1'b0;
`endif
            end else begin
                press_q <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                long_q  <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        deb_cnt <= '0;
`ifdef BTN_LONG_PRESS_EN
                        hold_cnt <= '0;
                        ret_held <= 1'b0;
`endif
                        if (s[i]) state <= DEB_PRESS;
                    end
                    DEB_PRESS: begin
                        if (!s[i]) begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                        end else if (deb_cnt == DEB_LAST) begin
                            state   <= PRESSED;
                            deb_cnt <= DEB_FULL;
                            press_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s[i]) begin
                            state   <= DEB_RELEASE;
                            deb_cnt <= '0;
                        end
`ifdef BTN_LONG_PRESS_EN
                        if (long_hit) begin
                            hold_cnt <= HOLD_FULL;
                            ret_held <= 1'b1;
                            long_q   <= 1'b1;
                            if (s[i]) state <= HELD;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
`endif
                    end
`ifdef BTN_LONG_PRESS_EN
                    HELD: begin
                        if (!s[i]) begin
                            state   <= DEB_RELEASE;
                            deb_cnt <= '0;
                        end
                    end
`endif
                    DEB_RELEASE: begin
                        if (s[i]) begin
`ifdef BTN_LONG_PRESS_EN
                            state <= ret_held ? HELD : PRESSED;
`else
                            state <= PRESSED;
`endif
                        end else if (deb_cnt == DEB_LAST) begin
                            state   <= IDLE;
                            deb_cnt <= '0;
                            level_q <= 1'b0;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
`ifdef BTN_LONG_PRESS_EN
                        // Hold time keeps running through a release bounce
                        if (long_hit) begin
                            hold_cnt <= HOLD_FULL;
                            ret_held <= 1'b1;
                            long_q   <= 1'b1;
                            if (s[i]) state <= HELD;
                        end else if (!ret_held) begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
